clint_timer: RTL

- System-bus responder implementing the machine timer and software-interrupt registers for NUM_HARTS cores.
- Sits on the system bus as a slave, answering the req/ready handshake that each core tile drives as master.
- Drives each tile's timer_irq input, plus one software-interrupt line per hart.
- Holds a 64-bit mtime, one 64-bit mtimecmp per hart, and one msip bit per hart.

---
 rtl/clint_timer.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/clint_timer.sv
// -----------------------------------------------------------------------------
// clint_timer
//
// Core-local interruptor: machine timer (mtime / mtimecmp) and machine
// software-interrupt (msip) registers for NUM_HARTS harts, reached through a
// simple req/ready bus slave port.
//
// Parameters
//   NUM_HARTS : number of harts served (1..16)
//   PRESCALE  : clk cycles per mtime increment (>= 1)
//   LATENCY   : cycles from the accept edge until bus_ready is sampled (>= 1)
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   bus_addr   byte address, only [15:2] decoded ([1:0] ignored)
//   bus_wdata  write data
//   bus_be     byte enables, bit i qualifies bits [8i+7:8i]
//   bus_we     1 = write, 0 = read
//   bus_req    request, held by the master until bus_ready
//   bus_rdata  read data, valid while bus_ready = 1 (0 for writes)
//   bus_ready  one-cycle completion pulse
//   timer_irq  per-hart machine timer interrupt (registered)
//   soft_irq   per-hart machine software interrupt (registered)
//
// Register map (offset = bus_addr[15:0])
//   0x0000 + 4h : msip[h] (bit 0)
//   0x4000 + 8h : mtimecmp[h] low word, 0x4004 + 8h : high word
//   0xBFF8      : mtime low word,       0xBFFC      : high word
//   anything else reads 0, ignores writes, and still completes the handshake
// -----------------------------------------------------------------------------
module clint_timer #(
  parameter int NUM_HARTS = 2,
  parameter int PRESCALE  = 1,
  parameter int LATENCY   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          bus_addr,
  input  logic [31:0]          bus_wdata,
  input  logic [3:0]           bus_be,
  input  logic                 bus_we,
  input  logic                 bus_req,
  output logic [31:0]          bus_rdata,
  output logic                 bus_ready,
  output logic [NUM_HARTS-1:0] timer_irq,
  output logic [NUM_HARTS-1:0] soft_irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_LOAD  = CW'(LATENCY - 1);

  // Word indices (byte offset >> 2) of the register blocks.
  localparam logic [13:0] MSIP_IDX     = 14'h0000;
  localparam logic [13:0] CMP_IDX      = 14'h1000;
  localparam logic [13:0] MTIME_LO_IDX = 14'h2FFE;
  localparam logic [13:0] MTIME_HI_IDX = 14'h2FFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 accept;

  // Transaction fields captured on the accept edge.
  logic [13:0]          widx_q;
  logic [31:0]          wdata_q;
  logic [3:0]           be_q;
  logic                 we_q;

  logic [PW-1:0]        presc_q, presc_d;
  logic                 tick;
  logic [63:0]          mtime_q, mtime_d;
  logic [63:0]          mtimecmp_q [NUM_HARTS];
  logic [63:0]          mtimecmp_d [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_q, msip_d;
  logic [NUM_HARTS-1:0] timer_irq_q, timer_irq_d;
  logic [NUM_HARTS-1:0] soft_irq_q;

  logic                 wr_en;
  logic                 mtime_wr_lo, mtime_wr_hi;
  logic [31:0]          rd_word;

  // Upper address bits are decoded outside this block; the low two are
  // ignored because every access is treated as word aligned.
  logic                 unused_addr_bits;
  assign unused_addr_bits = ^{bus_addr[31:16], bus_addr[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus_req) begin
          accept  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        // The counter holds the WAIT cycles still to spend; leave as it
        // decrements to zero so RESP is entered LATENCY-1 edges after accept.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      widx_q  <= bus_addr[15:2];
      wdata_q <= bus_wdata;
      be_q    <= bus_be;
      we_q    <= bus_we;
    end
  end

  assign wr_en       = (state_q == RESP) && we_q;
  assign mtime_wr_lo = wr_en && (be_q != 4'b0000) && (widx_q == MTIME_LO_IDX);
  assign mtime_wr_hi = wr_en && (be_q != 4'b0000) && (widx_q == MTIME_HI_IDX);

  // ---------------------------------------------------------------------------
  // Read mux (current register values, i.e. before any same-cycle tick)
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_word = 32'h0;
    if (widx_q == MTIME_LO_IDX) rd_word = mtime_q[31:0];
    if (widx_q == MTIME_HI_IDX) rd_word = mtime_q[63:32];
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (widx_q == MSIP_IDX + 14'(h))       rd_word = {31'b0, msip_q[h]};
      if (widx_q == CMP_IDX + 14'(2*h))      rd_word = mtimecmp_q[h][31:0];
      if (widx_q == CMP_IDX + 14'(2*h + 1))  rd_word = mtimecmp_q[h][63:32];
    end
  end

  assign bus_ready = (state_q == RESP);
  assign bus_rdata = ((state_q == RESP) && !we_q) ? rd_word : 32'h0;

  // ---------------------------------------------------------------------------
  // mtime prescaler and counter
  // ---------------------------------------------------------------------------
  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + 1'b1;
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    // A bus write suppresses that cycle's increment entirely: unwritten bytes
    // keep their pre-tick value, and the low word never carries upward.
    if (mtime_wr_lo) begin
      mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wdata_q, be_q)};
    end else if (mtime_wr_hi) begin
      mtime_d = {merge_bytes(mtime_q[63:32], wdata_q, be_q), mtime_q[31:0]};
    end
  end

  // ---------------------------------------------------------------------------
  // mtimecmp / msip write path and interrupt compare
  // ---------------------------------------------------------------------------
  always_comb begin
    msip_d = msip_q;
    for (int h = 0; h < NUM_HARTS; h++) begin
      mtimecmp_d[h] = mtimecmp_q[h];
      if (wr_en && be_q[0] && (widx_q == MSIP_IDX + 14'(h))) begin
        msip_d[h] = wdata_q[0];
      end
      if (wr_en && (widx_q == CMP_IDX + 14'(2*h))) begin
        mtimecmp_d[h][31:0] = merge_bytes(mtimecmp_q[h][31:0], wdata_q, be_q);
      end
      if (wr_en && (widx_q == CMP_IDX + 14'(2*h + 1))) begin
        mtimecmp_d[h][63:32] = merge_bytes(mtimecmp_q[h][63:32], wdata_q, be_q);
      end
    end
  end

  always_comb begin
    timer_irq_d = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      timer_irq_d[h] = (mtime_q >= mtimecmp_q[h]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      presc_q     <= '0;
      mtime_q     <= '0;
      msip_q      <= '0;
      timer_irq_q <= '0;
      soft_irq_q  <= '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        mtimecmp_q[h] <= '1;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      presc_q     <= presc_d;
      mtime_q     <= mtime_d;
      msip_q      <= msip_d;
      timer_irq_q <= timer_irq_d;
      soft_irq_q  <= msip_q;
      for (int h = 0; h < NUM_HARTS; h++) begin
        mtimecmp_q[h] <= mtimecmp_d[h];
      end
    end
  end

  assign timer_irq = timer_irq_q;
  assign soft_irq  = soft_irq_q;

endmodule
